rv32i_alu_issue: RTL and testbench
==================================

Name: rv32i_alu_issue

Overview:
- Decode/issue stage that produces the ALU operand interface (op, a, b) from RV32I instruction words and register-file read values.
- Covers OP, OP-IMM, LUI and AUIPC.
- Decodes the 5-bit ALU op code, selects the operands, and presents them through a registered 2-entry skid buffer with valid/ready handshakes on both sides.
- Sits between the register-read stage and the rv32i_alu execute stage.

Parameters:
CNT_W, 32, width of the issued-instruction counter; wraps modulo 2^CNT_W.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous; discards all buffered entries
in_valid  input  1  upstream entry valid
in_ready  output  1  stage can accept an entry
in_instr  input  32  instruction word
in_pc  input  32  instruction address
in_rs1_val  input  32  rs1 register value
in_rs2_val  input  32  rs2 register value
out_valid  output  1  issued entry valid
out_ready  input  1  ALU stage accepts the entry
out_op  output  5  ALU op code
out_a  output  32  operand a
out_b  output  32  operand b
out_rd  output  5  destination register (instr[11:7])
out_illegal  output  1  entry is not a supported ALU instruction
issue_count  output  CNT_W  count of completed output handshakes

Behaviour:
- ALU op codes (bit4 always 0):
  - ADD 00000, SLL 00001, SLT 00010, SLTU 00011, XOR 00100
  - SRL 00101, OR 00110, AND 00111, SUB 01000, SRA 01101
- Decode, by opcode instr[6:0]:
  - OP (0110011):
    - funct7=0000000: op={0,0,funct3}.
    - funct7=0100000 with funct3 000 or 101: op={0,1,funct3}.
    - Any other funct7: illegal.
    - a=rs1_val, b=rs2_val.
  - OP-IMM (0010011):
    - a=rs1_val, b=sign-extended instr[31:20].
    - funct3 000/010/011/100/110/111: op={0,0,funct3}; ADDI never maps to SUB.
    - funct3 001: instr[31:25] must be 0000000, else illegal.
    - funct3 101: instr[31:25]=0000000 gives SRL; 0100000 gives SRA; any other value is illegal.
    - For shifts, b keeps the full sign-extended immediate; the ALU uses only b[4:0].
  - LUI (0110111): op=ADD, a=0, b={instr[31:12],12'b0}.
  - AUIPC (0010111): op=ADD, a=in_pc, b={instr[31:12],12'b0}.
  - Any other opcode: illegal.
- Illegal entries are still issued, with out_illegal=1, op=ADD, a=0, b=0.
- Decode is combinational on in_*. Only the decoded fields are stored.
- Buffer: a main register (drives out_*) and a skid register.
  - in_ready = !skid_valid, driven directly from a flop. No combinational path from out_ready.
  - Accept = in_valid & in_ready.
  - Entry goes to main if main is empty or main is handshaking this cycle; otherwise it goes to skid.
  - On a main handshake (out_valid & out_ready) with skid valid: main <= skid and skid is emptied. A simultaneous accept then goes to skid.
  - Latency: an entry accepted at edge N is visible on out_* after edge N.
  - Throughput: one entry per cycle while out_ready=1.
  - While out_valid=1 and out_ready=0, all out_* hold stable.
  - Entries leave in acceptance order; none is dropped or duplicated (except on flush).
- Full: both entries valid gives in_ready=0 on the next cycle; in_valid is ignored while in_ready=0.
- Empty: out_valid=0; out_op/a/b/rd/illegal hold their last values. The bench checks them only while out_valid=1.
- flush:
  - Takes priority over every other event. At the edge, main_valid and skid_valid go to 0.
  - A same-cycle accept is discarded.
  - A same-cycle output handshake still counts in issue_count.
  - in_ready=1 in the next cycle.
- issue_count:
  - Increments by 1 per output handshake, regardless of out_illegal.
  - Wraps from all-ones to 0.
- Reset (asynchronous assert, any time including mid-transfer):
  - out_valid=0, skid empty, in_ready=1.
  - out_op=0, out_a=0, out_b=0, out_rd=0, out_illegal=0, issue_count=0.
  - Outputs reach these values without waiting for a clock edge.
  - The first accept happens at the first edge after rst_n deasserts.

Test Plan:
1. Reset, then ADDI x5,x1,-1 (instr 0xFFF08293), rs1_val=0x10, out_ready=1 -> one cycle later out_valid=1, op=00000, a=0x10, b=0xFFFFFFFF, rd=5, illegal=0; issue_count=1 after the handshake.
2. SUB (0x40208033), then SRAI x1,x1,3 (0x4030D093), then SRLI (0x0030D093) back-to-back -> ops 01000, 01101, 00101 in order; SRAI b=0x00000403, SRLI b=0x00000003.
3. out_ready=0 while 3 entries are offered -> first two accepted; in_ready=0 from the cycle after the second accept; out_* stable. Release out_ready -> all three emitted in order with no bubbles or drops.
4. AUIPC (0x12345017), pc=0x80000000 -> op=ADD, a=0x80000000, b=0x12345000. MUL (0x02208033) and a load (0x00002003) -> illegal=1, a=0, b=0, both still issued.
5. Both entries full, flush=1 in the same cycle as out_ready=1 and in_valid=1 -> next cycle out_valid=0, in_ready=1; issue_count +1; the offered entry is absent from the output.
6. rst_n asserted mid-stream with out_valid=1 -> out_valid=0 and issue_count=0 immediately. issue_count preset near all-ones with CNT_W=4 -> 16 handshakes wrap back to the same value.

Source files
------------

// File: rtl/rv32i_alu_issue_if.sv
// Operand-issue bus between register read, the issue stage and the ALU.
// slave: issue-stage view; master: producer/consumer (bench) view.
interface rv32i_alu_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_op;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [4:0]  out_rd;
    logic        out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, in_rs1_val, in_rs2_val,
        output in_ready,
        output out_valid, out_op, out_a, out_b, out_rd, out_illegal,
        input  out_ready
    );

    modport master (
        output in_valid, in_instr, in_pc, in_rs1_val, in_rs2_val,
        input  in_ready,
        input  out_valid, out_op, out_a, out_b, out_rd, out_illegal,
        output out_ready
    );
endinterface

// File: rtl/rv32i_alu_issue.sv
// RV32I ALU issue stage: decodes OP/OP-IMM/LUI/AUIPC into (op, a, b, rd)
// and issues through a 2-entry skid buffer.
// Ports: clk, rst_n (async low), flush, bus (slave), issue_count.
module rv32i_alu_issue #(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    rv32i_alu_issue_if.slave     bus,
    output logic [CNT_W-1:0]     issue_count
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [4:0] ALU_ADD = 5'b00000;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        illegal;
    } ent_t;

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    ent_t        dec;
    logic        legal;

    assign opc   = bus.in_instr[6:0];
    assign f3    = bus.in_instr[14:12];
    assign f7    = bus.in_instr[31:25];
    assign imm_i = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
    assign imm_u = {bus.in_instr[31:12], 12'b0};

    always_comb begin
        dec         = '0;
        dec.rd      = bus.in_instr[11:7];
        legal       = 1'b0;
        unique case (1'b1)
            opc == OPC_OP: begin
                dec.a = bus.in_rs1_val;
                dec.b = bus.in_rs2_val;
                if (f7 == 7'b0000000) begin
                    dec.op = {2'b00, f3};
                    legal  = 1'b1;
                end else if (f7 == 7'b0100000 &&
                             (f3 == 3'b000 || f3 == 3'b101)) begin
                    dec.op = {2'b01, f3};
                    legal  = 1'b1;
                end
            end
            opc == OPC_OPIMM: begin
                dec.a  = bus.in_rs1_val;
                dec.b  = imm_i;
                dec.op = {2'b00, f3};
                legal  = 1'b1;
                if (f3 == 3'b001) begin
                    legal = (f7 == 7'b0000000);
                end else if (f3 == 3'b101) begin
                    // funct7[5] selects SRA; any other funct7 bit is illegal
                    if (f7 == 7'b0100000) begin
                        dec.op = 5'b01101;
                    end else if (f7 != 7'b0000000) begin
                        legal = 1'b0;
                    end
                end
            end
            opc == OPC_LUI: begin
                dec.op = ALU_ADD;
                dec.a  = '0;
                dec.b  = imm_u;
                legal  = 1'b1;
            end
            opc == OPC_AUIPC: begin
                dec.op = ALU_ADD;
                dec.a  = bus.in_pc;
                dec.b  = imm_u;
                legal  = 1'b1;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
        if (!legal) begin
            dec.op = ALU_ADD;
            dec.a  = '0;
            dec.b  = '0;
        end
        dec.illegal = !legal;
    end

    ent_t main_q, main_d;
    ent_t skid_q, skid_d;
    logic main_v, main_vd;
    logic skid_v, skid_vd;
    logic rdy_q;
    logic acc;
    logic hs;
    logic [CNT_W-1:0] cnt_q;

    assign acc = bus.in_valid & rdy_q;
    assign hs  = main_v & bus.out_ready;

    always_comb begin
        main_d  = main_q;
        skid_d  = skid_q;
        main_vd = main_v;
        skid_vd = skid_v;
        if (flush) begin
            main_vd = 1'b0;
            skid_vd = 1'b0;
        end else if (hs || !main_v) begin
            // skid holds the older entry; acc cannot coincide since
            // in_ready is low whenever skid is occupied
            if (skid_v) begin
                main_d  = skid_q;
                main_vd = 1'b1;
                skid_vd = 1'b0;
            end else if (acc) begin
                main_d  = dec;
                main_vd = 1'b1;
            end else begin
                main_vd = 1'b0;
            end
        end else if (acc) begin
            skid_d  = dec;
            skid_vd = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
            main_v <= 1'b0;
            skid_v <= 1'b0;
            rdy_q  <= 1'b1;
            cnt_q  <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
            main_v <= main_vd;
            skid_v <= skid_vd;
            rdy_q  <= !skid_vd;
            if (hs) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready    = rdy_q;
    assign bus.out_valid   = main_v;
    assign bus.out_op      = main_q.op;
    assign bus.out_a       = main_q.a;
    assign bus.out_b       = main_q.b;
    assign bus.out_rd      = main_q.rd;
    assign bus.out_illegal = main_q.illegal;
    assign issue_count     = cnt_q;

endmodule

// File: tb/tb_rv32i_alu_issue.sv
// Scoreboard bench for rv32i_alu_issue: directed scenarios plus random
// traffic checked against a mnemonic-level decode model.
module tb_rv32i_alu_issue;

    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic [CNT_W-1:0] issue_count;

    rv32i_alu_issue_if bus ();

    rv32i_alu_issue #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .bus         (bus),
        .issue_count (issue_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cnt_model = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference decode written in terms of instruction mnemonics.
    function automatic exp_t ref_model(input logic [31:0] ins,
                                       input logic [31:0] pc,
                                       input logic [31:0] r1,
                                       input logic [31:0] r2);
        exp_t e;
        logic [31:0] immi;
        logic [31:0] immu;
        int f3;
        int f7;
        bit ok;
        f3   = int'(ins[14:12]);
        f7   = int'(ins[31:25]);
        immi = 32'($signed(ins[31:20]));
        immu = ins & 32'hFFFF_F000;
        e.rd = ins[11:7];
        e.op = 0;
        e.a  = 0;
        e.b  = 0;
        ok   = 0;
        case (ins[6:0])
            7'h33: begin
                e.a = r1; e.b = r2;
                if (f7 == 0) begin
                    // add sll slt sltu xor srl or and
                    e.op = 5'(f3); ok = 1;
                end else if (f7 == 32 && f3 == 0) begin
                    e.op = 5'd8; ok = 1;            // sub
                end else if (f7 == 32 && f3 == 5) begin
                    e.op = 5'd13; ok = 1;           // sra
                end
            end
            7'h13: begin
                e.a = r1; e.b = immi;
                if (f3 == 1) begin
                    ok = (f7 == 0); e.op = 5'd1;    // slli
                end else if (f3 == 5) begin
                    if (f7 == 0) begin
                        ok = 1; e.op = 5'd5;        // srli
                    end else if (f7 == 32) begin
                        ok = 1; e.op = 5'd13;       // srai
                    end
                end else begin
                    ok = 1; e.op = 5'(f3);
                end
            end
            7'h37: begin e.a = 0;  e.b = immu; ok = 1; end
            7'h17: begin e.a = pc; e.b = immu; ok = 1; end
            default: ok = 0;
        endcase
        if (!ok) begin
            e.op = 0; e.a = 0; e.b = 0;
        end
        e.ill = !ok;
        return e;
    endfunction

    // Monitor: checks count every cycle, pops on each output handshake,
    // and checks that a stalled output holds still.
    bit   stall_prev = 0;
    exp_t held;
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            chk("issue_count", 32'(issue_count), 32'(cnt_model));
            if (stall_prev && bus.out_valid) begin
                chk("hold_op", 32'(bus.out_op), 32'(held.op));
                chk("hold_a", bus.out_a, held.a);
                chk("hold_b", bus.out_b, held.b);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 32'(1), 32'(0));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("op", 32'(bus.out_op), 32'(e.op));
                    chk("a", bus.out_a, e.a);
                    chk("b", bus.out_b, e.b);
                    chk("rd", 32'(bus.out_rd), 32'(e.rd));
                    chk("illegal", 32'(bus.out_illegal), 32'(e.ill));
                end
                cnt_model = (cnt_model + 1) % (1 << CNT_W);
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            held.op = bus.out_op;
            held.a  = bus.out_a;
            held.b  = bus.out_b;
        end
    end

    // Driver bookkeeping: what was accepted/flushed in the last cycle.
    bit   acc_p = 0;
    bit   flush_p = 0;
    exp_t acc_e;

    task automatic step();
        @(posedge clk);
        #1;
        if (flush_p) exp_q.delete();
        else if (acc_p) exp_q.push_back(acc_e);
        acc_p = 0;
        flush_p = 0;
    endtask

    task automatic drive(input bit v, input logic [31:0] ins,
                         input logic [31:0] pc, input logic [31:0] r1,
                         input logic [31:0] r2, input bit ordy,
                         input bit fl);
        step();
        bus.in_valid   = v;
        bus.in_instr   = ins;
        bus.in_pc      = pc;
        bus.in_rs1_val = r1;
        bus.in_rs2_val = r2;
        bus.out_ready  = ordy;
        flush          = fl;
        acc_p   = v && bus.in_ready;
        flush_p = fl;
        acc_e   = ref_model(ins, pc, r1, r2);
    endtask

    // Offer one entry until accepted (bounded).
    task automatic send(input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] r1, input bit ordy);
        int k;
        k = 0;
        drive(1, ins, pc, r1, 32'h0BAD_F00D, ordy, 0);
        while (!acc_p && k < 20) begin
            drive(1, ins, pc, r1, 32'h0BAD_F00D, ordy, 0);
            k++;
        end
        if (!acc_p) chk("accept_timeout", 32'(0), 32'(1));
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, ordy, 0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int kind;
        w = $urandom;
        kind = $urandom_range(0, 5);
        case (kind)
            0: begin
                w[6:0] = 7'h33;
                case ($urandom_range(0, 2))
                    0: w[31:25] = 7'h00;
                    1: w[31:25] = 7'h20;
                    default: ;
                endcase
            end
            1, 2: begin
                w[6:0] = 7'h13;
                if ($urandom_range(0, 1) == 1)
                    w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            end
            3: w[6:0] = 7'h37;
            4: w[6:0] = 7'h17;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        logic [CNT_W-1:0] c0;
        bus.in_valid = 0; bus.in_instr = 0; bus.in_pc = 0;
        bus.in_rs1_val = 0; bus.in_rs2_val = 0; bus.out_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_in_ready", 32'(bus.in_ready), 32'(1));
        chk("rst_count", 32'(issue_count), 32'(0));
        @(negedge clk);
        rst_n = 1;
        mon_en = 1;

        // ADDI x5,x1,-1
        send(32'hFFF0_8293, 0, 32'h10, 1);
        idle(2, 1);
        chk("addi_count", 32'(issue_count), 32'(1));

        // SUB, SRAI, SRLI back to back
        send(32'h4020_8033, 0, 32'h55, 1);
        send(32'h4030_D093, 0, 32'h80000000, 1);
        send(32'h0030_D093, 0, 32'h80000000, 1);
        idle(2, 1);

        // stall: fill main+skid, then release
        send(32'h0020_8033, 0, 32'h1, 0);
        send(32'h0020_C033, 0, 32'h2, 0);
        drive(1, 32'h0020_E033, 0, 32'h3, 0, 0, 0);
        chk("full_in_ready", 32'(bus.in_ready), 32'(0));
        idle(2, 0);
        send(32'h0020_E033, 0, 32'h3, 1);
        idle(3, 1);

        // AUIPC, MUL, load
        send(32'h1234_5017, 32'h8000_0000, 32'h7, 1);
        send(32'h0220_8033, 0, 32'h9, 1);
        send(32'h0000_2003, 0, 32'h9, 1);
        idle(2, 1);

        // flush with both entries full, handshake and offer same cycle
        send(32'h0010_0093, 0, 32'h1, 0);
        send(32'h0020_0093, 0, 32'h1, 0);
        drive(1, 32'h0030_0093, 0, 32'h1, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 1, 0);
        chk("flush_in_ready", 32'(bus.in_ready), 32'(1));
        chk("flush_out_valid", 32'(bus.out_valid), 32'(0));
        idle(2, 1);

        // counter wrap: 16 handshakes return to the same value
        c0 = CNT_W'(cnt_model);
        for (int i = 0; i < 16; i++) send(32'h0010_0093, 0, i, 1);
        idle(3, 1);
        chk("count_wrap", 32'(issue_count), 32'(c0));

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, rand_instr(), $urandom, $urandom,
                  $urandom, ($urandom % 3) != 0, ($urandom % 50) == 0);
        end
        idle(4, 1);
        chk("drained", 32'(exp_q.size()), 32'(0));

        // async reset mid-stream
        send(32'h0010_0093, 0, 1, 0);
        send(32'h0020_0093, 0, 2, 0);
        @(posedge clk);
        #2;
        mon_en = 0;
        rst_n  = 0;
        #1;
        chk("areset_out_valid", 32'(bus.out_valid), 32'(0));
        chk("areset_count", 32'(issue_count), 32'(0));
        chk("areset_in_ready", 32'(bus.in_ready), 32'(1));
        chk("areset_a", bus.out_a, 32'(0));
        exp_q.delete();
        acc_p = 0;
        flush_p = 0;
        cnt_model = 0;
        stall_prev = 0;
        bus.in_valid = 0;
        @(negedge clk);
        rst_n = 1;
        mon_en = 1;
        send(32'h1234_50B7, 0, 0, 1);
        idle(3, 1);
        chk("post_reset_count", 32'(issue_count), 32'(1));
        chk("final_drained", 32'(exp_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
